// File: rtl/matmul_engine.sv
// Outer-product matrix engine: accumulates a[i]*b[j] into a MAX_DIM x MAX_DIM saturating signed array.
// Latency: start edge E0 -> done_o pulse between E(MAX_DIM+2) and E(MAX_DIM+3); 7 cycles at defaults.
// Backpressure: none; the engine consumes one operand pair per RUN cycle until operand A signals finish.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, acc_mode_i    run request (IDLE only); mode 0 clears C and ovf, mode 1 accumulates
//   start_send_o           send request to both operand register files (high in RUN)
//   a_vec_i, b_vec_i       A column k / B row k, element i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   a_finish_i, b_finish_i finish strobes from the operand files; termination follows A
//   busy_o, done_o, err_o  status: not-idle, end-of-run pulse, sticky finish disagreement
//   res_row_i, res_row_o   combinational readout of one row of C
//   ovf_o                  sticky per-element saturation flags, bit i*MAX_DIM+j
module matmul_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ACC_WIDTH  = 16,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int ROW_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           acc_mode_i,
    output logic                           start_send_o,
    input  logic [BUS_WIDTH-1:0]           a_vec_i,
    input  logic [BUS_WIDTH-1:0]           b_vec_i,
    input  logic                           a_finish_i,
    input  logic                           b_finish_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    input  logic [ROW_W-1:0]               res_row_i,
    output logic [MAX_DIM*ACC_WIDTH-1:0]   res_row_o,
    output logic [MAX_DIM*MAX_DIM-1:0]     ovf_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t state;
    logic   mode_q;

    logic [ACC_WIDTH-1:0]         c_q   [MAX_DIM][MAX_DIM];
    logic [ACC_WIDTH-1:0]         c_sat [MAX_DIM][MAX_DIM];
    logic [MAX_DIM*MAX_DIM-1:0]   ovf_hit;

    // Per-element multiply, widen by one bit, then clamp.
    for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
            logic signed [DATA_WIDTH-1:0]   a_el;
            logic signed [DATA_WIDTH-1:0]   b_el;
            logic signed [2*DATA_WIDTH-1:0] prod;
            logic        [ACC_WIDTH:0]      sum;

            assign a_el = a_vec_i[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH];
            assign b_el = b_vec_i[(gj+1)*DATA_WIDTH-1 -: DATA_WIDTH];
            assign prod = a_el * b_el;
            assign sum  = {c_q[gi][gj][ACC_WIDTH-1], c_q[gi][gj]}
                        + {{(ACC_WIDTH+1-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

            // The two top bits of the widened sum differ exactly when the result left the
            // ACC_WIDTH range; the top bit then gives the direction of the clamp.
            assign ovf_hit[gi*MAX_DIM+gj] = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
            assign c_sat[gi][gj] = !ovf_hit[gi*MAX_DIM+gj] ? sum[ACC_WIDTH-1:0]
                                 : (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
        end
    end

    // Control FSM; all outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            mode_q       <= 1'b0;
            start_send_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state  <= LOAD;
                        mode_q <= acc_mode_i;
                        busy_o <= 1'b1;
                    end
                end
                LOAD: begin
                    err_o        <= 1'b0;
                    state        <= RUN;
                    start_send_o <= 1'b1;
                end
                RUN: begin
                    if (a_finish_i != b_finish_i) begin
                        err_o <= 1'b1;
                    end
                    // start_send stays high through the finish cycle so the operand
                    // counters wrap back to zero for the next run.
                    if (a_finish_i) begin
                        state        <= DONE;
                        start_send_o <= 1'b0;
                        done_o       <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accumulator array and sticky overflow flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    c_q[i][j] <= '0;
                end
            end
            ovf_o <= '0;
        end else if (state == LOAD && !mode_q) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    c_q[i][j] <= '0;
                end
            end
            ovf_o <= '0;
        end else if (state == RUN && !a_finish_i) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    c_q[i][j] <= c_sat[i][j];
                end
            end
            ovf_o <= ovf_o | ovf_hit;
        end
    end

    always_comb begin
        res_row_o = '0;
        for (int j = 0; j < MAX_DIM; j++) begin
            res_row_o[j*ACC_WIDTH +: ACC_WIDTH] = c_q[res_row_i][j];
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
module tb_matmul_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        acc_mode = 1'b0;
    logic        start_send;
    logic [31:0] a_vec;
    logic [31:0] b_vec;
    logic        a_fin;
    logic        b_fin;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  res_row = 2'd0;
    logic [63:0] res_data;
    logic [15:0] ovf;

    int total = 0;
    int bad = 0;

    // Operand storage: A[i][k], B[k][j]
    logic signed [7:0] ma [4][4];
    logic signed [7:0] mb [4][4];
    int                exp_c [4][4];

    // Operand register file model
    logic [2:0] op_cnt;
    logic       b_fin_q;
    logic       b_late = 1'b0;

    always #5 clk = ~clk;

    matmul_engine dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .acc_mode_i   (acc_mode),
        .start_send_o (start_send),
        .a_vec_i      (a_vec),
        .b_vec_i      (b_vec),
        .a_finish_i   (a_fin),
        .b_finish_i   (b_fin),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .res_row_i    (res_row),
        .res_row_o    (res_data),
        .ovf_o        (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt  <= 3'd0;
            b_fin_q <= 1'b0;
        end else begin
            b_fin_q <= a_fin;
            if (start_send) op_cnt <= (op_cnt == 3'd4) ? 3'd0 : op_cnt + 3'd1;
        end
    end

    assign a_fin = (op_cnt == 3'd4);
    assign b_fin = b_late ? b_fin_q : a_fin;

    always_comb begin
        a_vec = '0;
        b_vec = '0;
        if (op_cnt < 3'd4) begin
            for (int i = 0; i < 4; i++) begin
                a_vec[i*8 +: 8] = ma[i][op_cnt[1:0]];
                b_vec[i*8 +: 8] = mb[op_cnt[1:0]][i];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_rows(input string tag);
        logic [63:0] pk;
        int          v;
        for (int r = 0; r < 4; r++) begin
            res_row = r[1:0];
            #1;
            pk = '0;
            for (int j = 0; j < 4; j++) begin
                v = exp_c[r][j];
                pk[j*16 +: 16] = v[15:0];
            end
            chk($sformatf("%s_row%0d", tag, r), res_data, pk);
        end
    endtask

    task automatic set_ident();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 8'sd1 : 8'sd0;
                mb[i][j] = 8'(i*4 + j + 1);
            end
        end
    endtask

    task automatic set_fill(input int av, input int bv);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 8'(av);
                mb[i][j] = 8'(bv);
            end
        end
    endtask

    task automatic exp_b_times(input int m);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp_c[i][j] = m * (i*4 + j + 1);
            end
        end
    endtask

    task automatic exp_fill(input int v);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp_c[i][j] = v;
            end
        end
    endtask

    // One run: k counts negedges after edge k past the start edge E0.
    task automatic run(input logic mode, input bit pulse, output int first, output int ndone,
                       output logic busy_k0, output logic err_k1);
        first   = -1;
        ndone   = 0;
        busy_k0 = 1'bx;
        err_k1  = 1'bx;
        @(negedge clk);
        start    = 1'b1;
        acc_mode = mode;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start   = 1'b0;
                busy_k0 = busy;
            end
            if (k == 1) err_k1 = err;
            if (pulse && k == 2) start = 1'b1;
            if (pulse && k == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
    endtask

    int   first;
    int   ndone;
    logic busy_k0;
    logic err_k1;

    initial begin
        set_ident();

        // Reset state
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_send", {63'd0, start_send}, 64'd0);
        chk("rst_ovf", {48'd0, ovf}, 64'd0);
        exp_fill(0);
        check_rows("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Identity run
        run(1'b0, 1'b0, first, ndone, busy_k0, err_k1);
        chk("id_busy_k0", {63'd0, busy_k0}, 64'd1);
        chk("id_done_at", 64'(first), 64'd6);
        chk("id_done_cnt", 64'(ndone), 64'd1);
        chk("id_ovf", {48'd0, ovf}, 64'd0);
        chk("id_err", {63'd0, err}, 64'd0);
        chk("id_busy_end", {63'd0, busy}, 64'd0);
        exp_b_times(1);
        check_rows("id");

        // Accumulate mode doubles, then clear mode restores
        run(1'b1, 1'b0, first, ndone, busy_k0, err_k1);
        exp_b_times(2);
        check_rows("acc");
        run(1'b0, 1'b0, first, ndone, busy_k0, err_k1);
        exp_b_times(1);
        check_rows("clr");

        // Positive saturation: 4*127*127 = 64516 -> 32767
        set_fill(127, 127);
        run(1'b0, 1'b0, first, ndone, busy_k0, err_k1);
        exp_fill(32767);
        check_rows("psat");
        chk("psat_ovf", {48'd0, ovf}, 64'h0000_0000_0000_FFFF);

        // Negative saturation: 4*(-128*127) = -65024 -> -32768
        set_fill(-128, 127);
        run(1'b0, 1'b0, first, ndone, busy_k0, err_k1);
        exp_fill(-32768);
        check_rows("nsat");
        chk("nsat_ovf", {48'd0, ovf}, 64'h0000_0000_0000_FFFF);

        // Signed, no saturation: 4*(-1*2) = -8, flags cleared by mode 0
        set_fill(-1, 2);
        run(1'b0, 1'b0, first, ndone, busy_k0, err_k1);
        exp_fill(-8);
        check_rows("neg");
        chk("neg_ovf", {48'd0, ovf}, 64'd0);

        // start pulsed while busy is ignored
        set_ident();
        run(1'b0, 1'b1, first, ndone, busy_k0, err_k1);
        chk("pulse_done_at", 64'(first), 64'd6);
        chk("pulse_done_cnt", 64'(ndone), 64'd1);
        exp_b_times(1);
        check_rows("pulse");

        // B finish one cycle late sets err; next run clears it in LOAD
        b_late = 1'b1;
        run(1'b0, 1'b0, first, ndone, busy_k0, err_k1);
        chk("late_err", {63'd0, err}, 64'd1);
        chk("late_done_at", 64'(first), 64'd6);
        b_late = 1'b0;
        run(1'b0, 1'b0, first, ndone, busy_k0, err_k1);
        chk("clr_err_k1", {63'd0, err_k1}, 64'd0);
        chk("clr_err_end", {63'd0, err}, 64'd0);

        // Reset mid-RUN, right after E3 (two accumulates done)
        set_fill(127, 127);
        @(negedge clk);
        start    = 1'b1;
        acc_mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_send", {63'd0, start_send}, 64'd0);
        chk("mrst_done", {63'd0, done}, 64'd0);
        chk("mrst_ovf", {48'd0, ovf}, 64'd0);
        exp_fill(0);
        check_rows("mrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Identity run after reset reproduces first result
        set_ident();
        run(1'b0, 1'b0, first, ndone, busy_k0, err_k1);
        chk("re_done_at", 64'(first), 64'd6);
        chk("re_done_cnt", 64'(ndone), 64'd1);
        chk("re_ovf", {48'd0, ovf}, 64'd0);
        chk("re_err", {63'd0, err}, 64'd0);
        exp_b_times(1);
        check_rows("re");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Compute core that sits directly downstream of the two operand register files (operand A and operand B). It drives their send-request lines, and consumes one A column vector and one B row vector per cycle. It accumulates the outer products into a MAX_DIM x MAX_DIM signed accumulator matrix with saturation. Results and per-element overflow flags are held for readout by the bus slave until the next run.

## Interface
- DATA_WIDTH, 8: signed operand element width.
- BUS_WIDTH, 32: operand vector width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (4 by default).
- ACC_WIDTH, 16: signed accumulator element width (must be >= 2*DATA_WIDTH).
- clk_i  in  1  single clock, all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  run request; accepted only in IDLE.
- acc_mode_i  in  1  sampled with start_i. 0 clears accumulators and flags before the run; 1 accumulates onto the existing contents.
- start_send_o  out  1  send request, wired to start_send_i of both operand modules.
- a_vec_i  in  BUS_WIDTH  A column k. Element i is at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- b_vec_i  in  BUS_WIDTH  B row k, same packing.
- a_finish_i  in  1  finish_send from operand A.
- b_finish_i  in  1  finish_send from operand B.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of run.
- err_o  out  1  sticky flag: A and B finish disagreed during a run.
- res_row_i  in  $clog2(MAX_DIM)  result row select.
- res_row_o  out  MAX_DIM*ACC_WIDTH  row res_row_i of C. Element j is at [(j+1)*ACC_WIDTH-1 -: ACC_WIDTH]. Combinational.
- ovf_o  out  MAX_DIM*MAX_DIM  sticky saturation flags; bit i*MAX_DIM+j corresponds to C[i][j].

## Operation
- The FSM has four states: IDLE, LOAD, RUN and DONE.
- IDLE -> LOAD when start_i=1. acc_mode_i is latched on that edge. start_i is ignored in all other states.
- LOAD is one cycle with start_send_o=0.
  - If the latched mode is 0: all C[i][j] <= 0 and ovf <= 0.
  - err is always cleared in LOAD.
  - LOAD -> RUN.
- RUN: start_send_o=1.
  - Accumulate cycle (a_finish_i=0): for every i,j, C[i][j] <= sat(C[i][j] + a[i]*b[j]).
  - Finish cycle (a_finish_i=1): no accumulation; RUN -> DONE.
  - Any RUN cycle with a_finish_i != b_finish_i sets err. Termination follows a_finish_i only.
- DONE: done_o=1, start_send_o=0. DONE -> IDLE.
- Arithmetic:
  - Operands are signed DATA_WIDTH values; each product is a signed 2*DATA_WIDTH value.
  - The sum is formed at ACC_WIDTH+1 bits and then saturated to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Whenever clamping occurs, ovf[i][j] is set and stays set.
- Readout: res_row_o is valid in every state. During RUN it shows partial sums. Results hold indefinitely in IDLE.
- Operand-side behaviour relied on:
  - Each operand module steps its read address 0..MAX_DIM-1 on consecutive cycles while start_send is high, and presents the vector combinationally.
  - It raises finish for exactly one cycle after MAX_DIM steps. Keeping start_send high through that cycle wraps its counter to 0, ready for the next run.

## Timing
- Reset values:
  - state=IDLE
  - start_send_o=0, busy_o=0, done_o=0, err_o=0
  - all C=0, so res_row_o=0
  - ovf_o=0
- Cycle numbering: start_i sampled at edge E0.
  - Cycle after E0: LOAD.
  - E1: enter RUN.
  - E2..E(MAX_DIM+1): MAX_DIM accumulate edges, one per k = 0..MAX_DIM-1.
  - E(MAX_DIM+2): finish sampled, enter DONE.
  - done_o is high between E(MAX_DIM+2) and E(MAX_DIM+3).
  - E(MAX_DIM+3): back in IDLE. A new start_i may be sampled at that edge.
  - Default total: done_o between E6 and E7.
- busy_o rises the cycle after E0 and falls after E(MAX_DIM+3). done_o and busy_o are both high in DONE.
- If no finish arrives, RUN persists. No timeout is defined; the upstream blocks are guaranteed to finish.
- Reset mid-run (any state): all registers return to reset values immediately. The operand modules share rst_ni, so their counters also restart.

## Test plan
- Identity check, default parameters.
  - Stimulus: A=I; B rows = {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}; acc_mode=0.
  - Response: res_row_o equals the B rows; done_o pulses exactly 7 cycles after the start edge (between E6 and E7); ovf_o=0, err_o=0.
- Accumulate mode.
  - Stimulus: repeat the identity run with acc_mode=1.
  - Response: every C element doubles (row 0 = {2,4,6,8}). A third run with acc_mode=0 restores single values.
- Positive saturation.
  - Stimulus: all A and B elements = 127.
  - Response: 4*16129 = 64516 exceeds 32767, so all C = 32767 (0x7FFF) and ovf_o = 0xFFFF.
- Negative saturation and signedness.
  - Stimulus: A all -128, B all 127.
  - Response: all C = -32768 (0x8000), ovf_o all ones.
  - Stimulus: A all -1, B all 2.
  - Response: all C = -8, ovf_o=0.
- Protocol errors.
  - Stimulus: start_i pulsed while busy.
  - Response: ignored; exactly one done_o pulse.
  - Stimulus: b_finish_i forced one cycle late.
  - Response: err_o=1 after the run; cleared in the LOAD cycle of the next run.
- Reset mid-RUN.
  - Stimulus: assert rst_ni low at E3.
  - Response: outputs go to reset values with no clock edge needed. A subsequent identity run reproduces the first scenario's result exactly.
